// File: rtl/ysyx_22040175_ifu.sv
// Instruction fetch unit: one outstanding imem request, flush/redirect via a drop flag.
// Optional IFU_ALIGN_CHECK_EN: misaligned fetch addresses fault locally without a bus request.
module ysyx_22040175_ifu #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] NOP_INST = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_fetch_pc,
    input  logic              i_fetch_en,
    input  logic              i_flush,
    output logic              o_imem_req_valid,
    input  logic              i_imem_req_ready,
    output logic [ADDR_W-1:0] o_imem_req_addr,
    input  logic              i_imem_rsp_valid,
    input  logic [ADDR_W-1:0] i_imem_rsp_data,
    input  logic              i_imem_rsp_err,
    output logic              o_inst_valid,
    output logic [ADDR_W-1:0] o_inst,
    output logic [ADDR_W-1:0] o_inst_pc,
    output logic              o_inst_err,
    input  logic              i_inst_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_e;

    state_e            r_state;
    state_e            w_next;
    logic              r_drop;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_inst;
    logic [ADDR_W-1:0] r_inst_pc;
    logic              r_inst_err;

    logic w_misaligned;
    logic w_start;
    logic w_capture;

`ifdef IFU_ALIGN_CHECK_EN
    assign w_misaligned = |i_fetch_pc[1:0];
`else
    assign w_misaligned = 1'b0;
`endif

    // A new fetch launches from IDLE, or back-to-back when the held instruction is consumed.
    assign w_start = !i_flush && i_fetch_en &&
                     ((r_state == S_IDLE) || ((r_state == S_HOLD) && i_inst_ready));

    assign w_capture = (r_state == S_WAIT) && i_imem_rsp_valid && !r_drop && !i_flush;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: default first so no path through the case leaves w_next unassigned (no latch).
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_next = w_misaligned ? S_HOLD : S_REQ;
            end
            S_REQ: begin
                if (i_imem_req_ready) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (i_imem_rsp_valid) w_next = (r_drop || i_flush) ? S_IDLE : S_HOLD;
            end
            S_HOLD: begin
                if (w_start)                       w_next = w_misaligned ? S_HOLD : S_REQ;
                else if (i_flush || i_inst_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs decoded from state and held registers only
    always_comb begin
        o_imem_req_valid = (r_state == S_REQ);
        o_imem_req_addr  = (r_state == S_REQ) ? r_addr : '0;
        o_inst_valid     = (r_state == S_HOLD);
        o_inst           = r_inst;
        o_inst_pc        = r_inst_pc;
        o_inst_err       = r_inst_err;
    end

    // Drop flag: a flush while a request is in flight poisons its response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop <= 1'b0;
        end else if ((r_state == S_REQ) && i_flush) begin
            r_drop <= 1'b1;
        end else if ((r_state == S_WAIT) && i_imem_rsp_valid) begin
            r_drop <= 1'b0;
        end else if ((r_state == S_WAIT) && i_flush) begin
            r_drop <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
        end else if (w_start) begin
            r_addr <= i_fetch_pc;
        end
    end

    // Held instruction; returns to NOP/0 whenever HOLD is left without reloading.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inst     <= NOP_INST;
            r_inst_pc  <= '0;
            r_inst_err <= 1'b0;
        end else if (w_capture) begin
            r_inst     <= i_imem_rsp_data;
            r_inst_pc  <= r_addr;
            r_inst_err <= i_imem_rsp_err;
        end else if (w_start && w_misaligned) begin
            r_inst     <= NOP_INST;
            r_inst_pc  <= i_fetch_pc;
            r_inst_err <= 1'b1;
        end else if ((r_state == S_HOLD) && (w_next != S_HOLD)) begin
            r_inst     <= NOP_INST;
            r_inst_pc  <= '0;
            r_inst_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ysyx_22040175_ifu.sv
// Self-checking bench for ysyx_22040175_ifu: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the fetch unit.
module tb_ysyx_22040175_ifu;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] fetch_pc = '0;
    logic        fetch_en = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] req_addr;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        rsp_err = 1'b0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_err;
    logic        inst_ready = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int n_hs     = 0;
    bit cmp_en   = 1'b0;

    ysyx_22040175_ifu dut (
        .clk              (clk),
        .rst              (rst),
        .i_fetch_pc       (fetch_pc),
        .i_fetch_en       (fetch_en),
        .i_flush          (flush),
        .o_imem_req_valid (req_valid),
        .i_imem_req_ready (req_ready),
        .o_imem_req_addr  (req_addr),
        .i_imem_rsp_valid (rsp_valid),
        .i_imem_rsp_data  (rsp_data),
        .i_imem_rsp_err   (rsp_err),
        .o_inst_valid     (inst_valid),
        .o_inst           (inst),
        .o_inst_pc        (inst_pc),
        .o_inst_err       (inst_err),
        .i_inst_ready     (inst_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a pending request, an outstanding bus transfer, a held instruction.
    bit          m_req, m_out, m_drop, m_held, m_err;
    logic [31:0] m_addr, m_data, m_pc;

    task automatic m_clear();
        m_req = 0; m_out = 0; m_drop = 0; m_held = 0; m_err = 0;
        m_addr = '0; m_data = NOP; m_pc = '0;
    endtask

    task automatic m_launch(input logic [31:0] a);
`ifdef IFU_ALIGN_CHECK_EN
        if (a[1:0] != 2'b00) begin
            m_held = 1; m_data = NOP; m_pc = a; m_err = 1;
            return;
        end
`endif
        m_req  = 1;
        m_addr = a;
    endtask

    initial begin
        m_clear();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_clear();
            end else if (m_held) begin
                if (flush) begin
                    m_held = 0;
                end else if (inst_ready) begin
                    m_held = 0;
                    if (fetch_en) m_launch(fetch_pc);
                end
            end else if (m_req) begin
                if (flush) m_drop = 1;
                if (req_ready) begin
                    m_req = 0;
                    m_out = 1;
                end
            end else if (m_out) begin
                if (rsp_valid) begin
                    m_out = 0;
                    if (!(m_drop || flush)) begin
                        m_held = 1; m_data = rsp_data; m_pc = m_addr; m_err = rsp_err;
                    end
                    m_drop = 0;
                end else if (flush) begin
                    m_drop = 1;
                end
            end else if (fetch_en && !flush) begin
                m_launch(fetch_pc);
            end
            if (!m_held) begin
                m_data = NOP; m_pc = '0; m_err = 0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            check("cyc_req_valid",  32'(req_valid),  32'(m_req));
            check("cyc_req_addr",   req_addr,        m_req ? m_addr : 32'h0);
            check("cyc_inst_valid", 32'(inst_valid), 32'(m_held));
            check("cyc_inst",       inst,            m_data);
            check("cyc_inst_pc",    inst_pc,         m_pc);
            check("cyc_inst_err",   32'(inst_err),   32'(m_err));
        end
    end

    initial forever begin
        @(posedge clk);
        if (req_valid && req_ready) n_hs++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    int          hs0;
    bit          mem_pending = 0;
    int          mem_delay   = 0;
    logic [31:0] mem_data    = '0;
    bit          mem_err     = 0;

    initial begin
        // Reset values
        #2 rst = 1'b1;
        #1 cmp_en = 1'b1;
        tick();
        check("rst_req_valid",  32'(req_valid),  32'h0);
        check("rst_req_addr",   req_addr,        32'h0);
        check("rst_inst_valid", 32'(inst_valid), 32'h0);
        check("rst_inst",       inst,            NOP);
        check("rst_inst_pc",    inst_pc,         32'h0);
        check("rst_inst_err",   32'(inst_err),   32'h0);

        // Minimum-latency fetch with a zero-wait memory
        rst = 0; fetch_en = 1; fetch_pc = 32'h8000_0000; req_ready = 1;
        tick();
        fetch_en = 0;
        check("lat_req_valid", 32'(req_valid), 32'h1);
        check("lat_req_addr",  req_addr,       32'h8000_0000);
        tick();
        check("lat_wait_req_valid",  32'(req_valid),  32'h0);
        check("lat_wait_inst_valid", 32'(inst_valid), 32'h0);
        rsp_valid = 1; rsp_data = 32'h0000_0093;
        tick();
        rsp_valid = 0;
        check("lat_inst_valid", 32'(inst_valid), 32'h1);
        check("lat_inst",       inst,            32'h0000_0093);
        check("lat_inst_pc",    inst_pc,         32'h8000_0000);
        check("lat_inst_err",   32'(inst_err),   32'h0);

        // Core stalls in HOLD, then consumes with a back-to-back fetch
        inst_ready = 0; req_ready = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_inst_valid", 32'(inst_valid), 32'h1);
            check("hold_inst",       inst,            32'h0000_0093);
        end
        inst_ready = 1; fetch_en = 1; fetch_pc = 32'h8000_0004; hs0 = n_hs;
        tick();
        inst_ready = 0; fetch_en = 0;
        check("b2b_req_valid",  32'(req_valid),  32'h1);
        check("b2b_req_addr",   req_addr,        32'h8000_0004);
        check("b2b_inst_valid", 32'(inst_valid), 32'h0);
        check("b2b_inst_nop",   inst,            NOP);

        // Memory backpressure: request held stable
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_req_valid", 32'(req_valid), 32'h1);
            check("bp_req_addr",  req_addr,       32'h8000_0004);
        end
        req_ready = 1;
        tick();
        req_ready = 0;
        check("bp_after_hs_valid", 32'(req_valid), 32'h0);
        check("bp_handshakes",     32'(n_hs - hs0), 32'h1);

        // Flush in WAIT, response two cycles later is discarded
        flush = 1;
        tick();
        flush = 0;
        tick();
        rsp_valid = 1; rsp_data = 32'h1234_5678;
        tick();
        rsp_valid = 0;
        check("flw_inst_valid", 32'(inst_valid), 32'h0);
        check("flw_req_valid",  32'(req_valid),  32'h0);

        // Drop cleared: the next fetch is delivered, carrying a bus error
        fetch_en = 1; fetch_pc = 32'h8000_0008; req_ready = 1;
        tick();
        fetch_en = 0;
        check("err_req_addr", req_addr, 32'h8000_0008);
        tick();
        rsp_valid = 1; rsp_data = 32'hdead_beef; rsp_err = 1;
        tick();
        rsp_valid = 0; rsp_err = 0;
        check("err_inst_valid", 32'(inst_valid), 32'h1);
        check("err_inst",       inst,            32'hdead_beef);
        check("err_inst_pc",    inst_pc,         32'h8000_0008);
        check("err_inst_err",   32'(inst_err),   32'h1);

        // Flush in HOLD clears the held instruction at once
        flush = 1;
        tick();
        flush = 0;
        check("flh_inst_valid", 32'(inst_valid), 32'h0);
        check("flh_inst",       inst,            NOP);
        check("flh_inst_pc",    inst_pc,         32'h0);
        check("flh_inst_err",   32'(inst_err),   32'h0);

        // Reset in WAIT, then a stray response is ignored
        fetch_en = 1; fetch_pc = 32'h8000_0010;
        tick();
        fetch_en = 0;
        tick();
        rst = 1;
        #1;
        check("arst_req_valid",  32'(req_valid),  32'h0);
        check("arst_req_addr",   req_addr,        32'h0);
        check("arst_inst_valid", 32'(inst_valid), 32'h0);
        check("arst_inst",       inst,            NOP);
        tick();
        rst = 0;
        tick();
        rsp_valid = 1; rsp_data = 32'hcafe_f00d;
        tick();
        rsp_valid = 0;
        check("stray_inst_valid", 32'(inst_valid), 32'h0);
        tick();
        check("stray_inst_valid2", 32'(inst_valid), 32'h0);
        check("stray_req_valid",   32'(req_valid),  32'h0);

        // Misaligned fetch address
        fetch_en = 1; fetch_pc = 32'h8000_0002;
        tick();
        fetch_en = 0;
`ifdef IFU_ALIGN_CHECK_EN
        check("mis_req_valid",  32'(req_valid),  32'h0);
        check("mis_inst_valid", 32'(inst_valid), 32'h1);
        check("mis_inst",       inst,            NOP);
        check("mis_inst_pc",    inst_pc,         32'h8000_0002);
        check("mis_inst_err",   32'(inst_err),   32'h1);
`else
        check("mis_req_valid", 32'(req_valid), 32'h1);
        check("mis_req_addr",  req_addr,       32'h8000_0002);
        tick();
        rsp_valid = 1; rsp_data = 32'h0010_0073;
        tick();
        rsp_valid = 0;
        check("mis_inst",    inst,    32'h0010_0073);
        check("mis_inst_pc", inst_pc, 32'h8000_0002);
`endif
        inst_ready = 1;
        tick();
        inst_ready = 0;
        check("mis_consumed", 32'(inst_valid), 32'h0);

        // Randomized traffic with a variable-latency memory
        for (int c = 0; c < 4000; c++) begin
            if (rst) begin
                rst = 0;
            end else if ($urandom_range(0, 599) == 0) begin
                rst = 1; mem_pending = 0; rsp_valid = 0;
                tick();
                continue;
            end
            rsp_valid = 0;
            if (mem_pending) begin
                if (mem_delay == 0) begin
                    rsp_valid = 1; rsp_data = mem_data; rsp_err = mem_err; mem_pending = 0;
                end else begin
                    mem_delay--;
                end
            end else if ($urandom_range(0, 9) == 0) begin
                rsp_valid = 1; rsp_data = $urandom; rsp_err = 1'($urandom_range(0, 1));
            end
            fetch_en   = ($urandom_range(0, 3) != 0);
            fetch_pc   = $urandom & (($urandom_range(0, 4) == 0) ? 32'hffff_ffff : 32'hffff_fffc);
            flush      = ($urandom_range(0, 11) == 0);
            inst_ready = 1'($urandom_range(0, 1));
            req_ready  = ($urandom_range(0, 2) != 0);
            if (req_valid && req_ready && !mem_pending) begin
                mem_pending = 1;
                mem_delay   = $urandom_range(0, 3);
                mem_data    = $urandom;
                mem_err     = ($urandom_range(0, 5) == 0);
            end
            tick();
        end

        rst = 0; fetch_en = 0; flush = 0; rsp_valid = 0;
        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ysyx_22040175_ifu.md
# ysyx_22040175_ifu

Instruction fetch unit sitting directly upstream of the single-cycle core top. It takes the current PC from the core, fetches one 32-bit instruction over a valid/ready instruction-memory bus, and presents it to the core's `inst` input with a valid/ready handshake. It supports flush/redirect by discarding in-flight responses. It keeps at most one request outstanding.

## Interface
- `ADDR_W`, 32: address and data width; matches `CPU_WIDTH`.
- `NOP_INST`, 32'h0000_0013: value driven on `inst` while no valid instruction is held.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `fetch_pc` in ADDR_W: address to fetch, driven by the PC register.
- `fetch_en` in 1: core requests a fetch of `fetch_pc`.
- `flush` in 1: discard any pending or held instruction (branch/jump redirect).
- `imem_req_valid` out 1: request valid.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_req_addr` out ADDR_W: request address.
- `imem_rsp_valid` in 1: response data valid; always accepted, with no backpressure.
- `imem_rsp_data` in ADDR_W: response instruction word.
- `imem_rsp_err` in 1: bus error on this response.
- `inst_valid` out 1: `inst` holds a fetched instruction.
- `inst` out ADDR_W: instruction to the core.
- `inst_pc` out ADDR_W: address the instruction was fetched from.
- `inst_err` out 1: fetch fault for this instruction.
- `inst_ready` in 1: core consumes the instruction this cycle.

## Operation
- States: IDLE, REQ, WAIT, HOLD. A 1-bit `drop` flag marks an in-flight request whose response must be discarded.
- **IDLE**
  - If `fetch_en` and not `flush`: latch `fetch_pc` into the address register and go to REQ.
- **REQ**
  - `imem_req_valid`=1 and `imem_req_addr` = latched address.
  - Once asserted, valid and address stay stable until `imem_req_ready`.
  - On `imem_req_ready`: go to WAIT.
  - `flush` in REQ sets `drop`. The request is not withdrawn.
- **WAIT**
  - On `imem_rsp_valid`:
    - If `drop` or `flush`: discard the response, clear `drop`, go to IDLE.
    - Otherwise: capture data into `inst`, the address into `inst_pc`, and `imem_rsp_err` into `inst_err`, then go to HOLD.
  - `flush` in WAIT without a response sets `drop`.
- **HOLD**
  - `inst_valid`=1.
  - If `flush`: go to IDLE.
  - Else on `inst_ready`:
    - If `fetch_en`: latch `fetch_pc` and go to REQ (back-to-back).
    - Otherwise go to IDLE.
- `flush` has priority over `inst_ready` in HOLD, and over capture in WAIT.
- On leaving HOLD, `inst` returns to `NOP_INST`, and `inst_pc` and `inst_err` return to 0.
- `imem_rsp_valid` outside WAIT is ignored.
- The latched address is used unmodified; no increment logic. Next-PC computation stays in the core.

## Timing
- Reset values:
  - State IDLE, `drop`=0, address register 0.
  - `imem_req_valid`=0, `imem_req_addr`=0.
  - `inst_valid`=0, `inst`=`NOP_INST`, `inst_pc`=0, `inst_err`=0.
- Reset asserted mid-transaction returns to IDLE immediately. The outstanding response is not tracked after reset.
- All outputs are registered or decoded from state only; there is no combinational path from `imem_rsp_*` to `inst*`.
- Minimum latency with a zero-wait memory:
  - Cycle 0: `fetch_en` sampled.
  - Cycle 1: `imem_req_valid`; handshake.
  - Cycle 2: response.
  - Cycle 3: `inst_valid`.
- Back-to-back throughput is one instruction per 3 cycles.
- `flush` takes effect at the same edge it is sampled. An instruction held in HOLD is never presented after a flush cycle.

## Configuration
- `IFU_ALIGN_CHECK_EN` defined:
  - In IDLE (or HOLD→REQ), a latched address with bits [1:0] ≠ 0 skips REQ/WAIT and goes directly to HOLD.
  - In HOLD it presents `inst`=`NOP_INST`, `inst_err`=1 and `inst_pc`=the address, with no bus request.
- Not defined: no alignment check; every address is issued to the bus unchanged.

## Test plan
- Reset, then `fetch_pc`=0x8000_0000 with `fetch_en`=1, zero-wait memory returning 0x0000_0093 → request issued with address 0x8000_0000; `inst_valid` on cycle 3 with `inst`=0x0000_0093, `inst_pc`=0x8000_0000.
- `imem_req_ready` low for 4 cycles → `imem_req_valid` and address stable across all 4 cycles; exactly one handshake.
- `flush` pulsed one cycle in WAIT, response arrives 2 cycles later → response discarded, `inst_valid` stays 0; state IDLE; `drop` cleared.
- `inst_ready` held low 5 cycles in HOLD, then `inst_ready`=1 with `fetch_en`=1 and `fetch_pc`=0x8000_0004 → `inst` stable for 5 cycles; next request to 0x8000_0004 issued the following cycle.
- `imem_rsp_err`=1 → `inst_err`=1 with `inst_valid`=1. With `IFU_ALIGN_CHECK_EN`, `fetch_pc`=0x8000_0002 → no `imem_req_valid`; `inst_err`=1, `inst`=0x0000_0013.
- `rst` asserted in WAIT → all outputs at reset values the same cycle; a later stray `imem_rsp_valid` is ignored.
